// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode/alarm controller: state codes,
// edit-field widths and wrap limits.
package clock_pkg;

  localparam int H_W   = 5;
  localparam int M10_W = 3;
  localparam int M1_W  = 4;

  localparam logic [H_W-1:0]   H_MAX   = 5'd23;
  localparam logic [M10_W-1:0] M10_MAX = 3'd5;
  localparam logic [M1_W-1:0]  M1_MAX  = 4'd9;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_H   = 3'd1,
    ST_SET_M10 = 3'd2,
    ST_SET_M1  = 3'd3,
    ST_ALM_H   = 3'd4,
    ST_ALM_M10 = 3'd5,
    ST_ALM_M1  = 3'd6
  } state_t;

endpackage

// File: rtl/clock_ctrl_key_edge.sv
// Press detector for one debounced active-low key: one history register,
// one-cycle press pulse on a 1 -> 0 transition.
module key_edge
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_reg <= 1'b1;
    else        hist_reg <= key;
  end

  assign press = hist_reg & ~key;

endmodule

// File: rtl/clock_ctrl.sv
// Mode/alarm controller for the 24-hour clock: key-driven time/alarm editing,
// one-cycle preset strobes, alarm ring with timeout. Optional snooze: SNOOZE_EN.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iKEY_MODE,
  input  logic             iKEY_INC,
  input  logic             iTICK_1S,
  input  logic [H_W-1:0]   iHOUR,
  input  logic [M10_W-1:0] iMIN10,
  input  logic [M1_W-1:0]  iMIN1,
  output logic             oPRSTn_H,
  output logic             oPRSTn_M10,
  output logic             oPRSTn_M1,
  output logic [H_W-1:0]   oDATA_H,
  output logic [M10_W-1:0] oDATA_M10,
  output logic [M1_W-1:0]  oDATA_M1,
  output logic [2:0]       oMODE,
  output logic [H_W-1:0]   oALM_H,
  output logic [M10_W-1:0] oALM_M10,
  output logic [M1_W-1:0]  oALM_M1,
  output logic             oARMED,
  output logic             oALARM
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  logic mode_press, inc_press;
  logic mode_act, inc_act;
  logic load_time, preset, commit, arm_toggle;
  logic inc_h, inc_m10, inc_m1;
  logic match_now, ring_start, ring_restart;

  state_t           state_reg, state_next;
  logic [H_W-1:0]   h_reg, alm_h_reg;
  logic [M10_W-1:0] m10_reg, alm_m10_reg;
  logic [M1_W-1:0]  m1_reg, alm_m1_reg;
  logic             prst_reg, armed_reg, alarm_reg;
  logic             match_reg, match_prev_reg;
  logic [7:0]       ring_cnt_reg;

  key_edge u_key_mode (.clk(iCLK), .rst_n(iRSTn), .key(iKEY_MODE), .press(mode_press));
  key_edge u_key_inc  (.clk(iCLK), .rst_n(iRSTn), .key(iKEY_INC),  .press(inc_press));

`ifdef SNOOZE_EN
  localparam logic [9:0] SNOOZE_END  = 10'(SNOOZE_SEC);
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);

  logic       snooze_reg;
  logic [9:0] snooze_cnt_reg;

  // A pending snooze holds at its end count until the state is back in RUN.
  assign ring_restart = snooze_reg && (state_reg == ST_RUN) &&
                        ((snooze_cnt_reg == SNOOZE_END) ||
                         (iTICK_1S && (snooze_cnt_reg == SNOOZE_LAST)));
  assign mode_act = mode_press & ~alarm_reg & ~snooze_reg;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      snooze_reg     <= 1'b0;
      snooze_cnt_reg <= '0;
    end else if (alarm_reg && inc_press && !mode_press) begin
      snooze_reg     <= 1'b1;
      snooze_cnt_reg <= '0;
    end else if (alarm_reg && mode_press) begin
      snooze_reg <= 1'b0;
    end else if (snooze_reg) begin
      if (mode_press || ring_restart || ring_start || (arm_toggle && armed_reg))
        snooze_reg <= 1'b0;
      else if (iTICK_1S && (snooze_cnt_reg != SNOOZE_END))
        snooze_cnt_reg <= snooze_cnt_reg + 1'b1;
    end
  end
`else
  assign ring_restart = 1'b0;
  assign mode_act     = mode_press & ~alarm_reg;
`endif

  // MODE wins over a simultaneous INC; any press while ringing only dismisses.
  assign inc_act = inc_press & ~mode_press & ~alarm_reg;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:     if (mode_act) state_next = ST_SET_H;
      ST_SET_H:   if (mode_act) state_next = ST_SET_M10;
      ST_SET_M10: if (mode_act) state_next = ST_SET_M1;
      ST_SET_M1:  if (mode_act) state_next = ST_ALM_H;
      ST_ALM_H:   if (mode_act) state_next = ST_ALM_M10;
      ST_ALM_M10: if (mode_act) state_next = ST_ALM_M1;
      ST_ALM_M1:  if (mode_act) state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  always_comb begin
    load_time  = 1'b0;
    preset     = 1'b0;
    commit     = 1'b0;
    arm_toggle = 1'b0;
    inc_h      = 1'b0;
    inc_m10    = 1'b0;
    inc_m1     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        load_time  = mode_act;
        arm_toggle = inc_act;
      end
      ST_SET_H, ST_ALM_H:     inc_h   = inc_act;
      ST_SET_M10, ST_ALM_M10: inc_m10 = inc_act;
      ST_SET_M1: begin
        preset = mode_act;
        inc_m1 = inc_act;
      end
      ST_ALM_M1: begin
        commit = mode_act;
        inc_m1 = inc_act;
      end
      default: ;
    endcase
  end

  // Fields keep the edited time through the strobe cycle, then take the alarm.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      h_reg    <= '0;
      m10_reg  <= '0;
      m1_reg   <= '0;
      prst_reg <= 1'b1;
    end else begin
      prst_reg <= ~preset;
      if (load_time) begin
        h_reg   <= iHOUR;
        m10_reg <= iMIN10;
        m1_reg  <= iMIN1;
      end else if (!prst_reg) begin
        h_reg   <= alm_h_reg;
        m10_reg <= alm_m10_reg;
        m1_reg  <= alm_m1_reg;
      end else begin
        if (inc_h)   h_reg   <= (h_reg   >= H_MAX)   ? '0 : h_reg   + 1'b1;
        if (inc_m10) m10_reg <= (m10_reg >= M10_MAX) ? '0 : m10_reg + 1'b1;
        if (inc_m1)  m1_reg  <= (m1_reg  >= M1_MAX)  ? '0 : m1_reg  + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      alm_h_reg   <= '0;
      alm_m10_reg <= '0;
      alm_m1_reg  <= '0;
      armed_reg   <= 1'b0;
    end else if (commit) begin
      alm_h_reg   <= h_reg;
      alm_m10_reg <= m10_reg;
      alm_m1_reg  <= m1_reg;
      armed_reg   <= 1'b1;
    end else if (arm_toggle) begin
      armed_reg <= ~armed_reg;
    end
  end

  assign match_now  = ({iHOUR, iMIN10, iMIN1} == {alm_h_reg, alm_m10_reg, alm_m1_reg});
  assign ring_start = match_reg & ~match_prev_reg & (state_reg == ST_RUN) & armed_reg;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      match_reg      <= 1'b0;
      match_prev_reg <= 1'b0;
      alarm_reg      <= 1'b0;
      ring_cnt_reg   <= '0;
    end else begin
      match_reg      <= match_now;
      match_prev_reg <= match_reg;
      if (alarm_reg) begin
        if (mode_press || inc_press) begin
          alarm_reg <= 1'b0;
        end else if (iTICK_1S) begin
          if (ring_cnt_reg == RING_LAST) alarm_reg <= 1'b0;
          ring_cnt_reg <= ring_cnt_reg + 1'b1;
        end
      end else if (ring_start || ring_restart) begin
        alarm_reg    <= 1'b1;
        ring_cnt_reg <= '0;
      end
    end
  end

  assign oPRSTn_H   = prst_reg;
  assign oPRSTn_M10 = prst_reg;
  assign oPRSTn_M1  = prst_reg;
  assign oDATA_H    = h_reg;
  assign oDATA_M10  = m10_reg;
  assign oDATA_M1   = m1_reg;
  assign oMODE      = state_reg;
  assign oALM_H     = alm_h_reg;
  assign oALM_M10   = alm_m10_reg;
  assign oALM_M1    = alm_m1_reg;
  assign oARMED     = armed_reg;
  assign oALARM     = alarm_reg;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and alarm controller for the 24-hour clock datapath. It turns two debounced push keys into a set-time / set-alarm sequence and edits hour, ten-minute and one-minute fields with wrap-around. It commits a new time to the preset counters through one-cycle active-low preset strobes, stores the alarm time, and drives the alarm output with an auto-timeout. It sits between the board keys and the counter chain, and replaces ad-hoc switch-selected presetting.

## Interface
- RING_SEC, 30, alarm auto-off after this many 1 s ticks (1..255)
- SNOOZE_SEC, 300, snooze delay in 1 s ticks (1..1023); used only with SNOOZE_EN
- iCLK  in  1  system clock (50 MHz)
- iRSTn  in  1  reset, asynchronous, active-low
- iKEY_MODE  in  1  debounced key, low = pressed
- iKEY_INC  in  1  debounced key, low = pressed
- iTICK_1S  in  1  one-cycle pulse once per second from the counter chain
- iHOUR  in  5  current hour, 0..23
- iMIN10  in  3  current ten-minutes, 0..5
- iMIN1  in  4  current minutes, 0..9
- oPRSTn_H, oPRSTn_M10, oPRSTn_M1  out  1 each  active-low preset strobes to the counters
- oDATA_H / oDATA_M10 / oDATA_M1  out  5/3/4  edit-field values; preset data while strobing
- oMODE  out  3  current state encoding
- oALM_H / oALM_M10 / oALM_M1  out  5/3/4  stored alarm time
- oARMED  out  1  alarm enabled
- oALARM  out  1  alarm ringing

## Operation
- Press detection:
  - Each key is registered once.
  - A press is previous=1 and current=0.
  - One press produces exactly one action, however long the key is held.
- States and oMODE codes:
  - RUN=0, SET_H=1, SET_M10=2, SET_M1=3, ALM_H=4, ALM_M10=5, ALM_M1=6.
  - Codes 7 and above are illegal and recover to RUN on the next clock.
- MODE press advances the state: RUN→SET_H→SET_M10→SET_M1→ALM_H→ALM_M10→ALM_M1→RUN.
- RUN→SET_H loads the edit fields from iHOUR/iMIN10/iMIN1.
- SET_M1→ALM_H:
  - All three preset strobes go low together for one cycle, with oDATA_* holding the edited time.
  - The edit fields are then loaded from the stored alarm.
- ALM_M1→RUN commits the edit fields to oALM_* and sets oARMED=1.
- INC press in a SET_*/ALM_* state increments the active field. Wrap rules: H 23→0, M10 5→0, M1 9→0. No carry between fields.
- INC press in RUN while not ringing toggles oARMED.
- Both keys pressed in the same cycle: MODE wins and INC is dropped.
- Match = {iHOUR,iMIN10,iMIN1} equals oALM_*.
- Ring start requires all of: the cycle after match rises, state is RUN, and oARMED=1. This gives at most one ring per matching minute.
- A match rise outside RUN is lost; it is not deferred.
- While ringing:
  - oALARM=1 and a tick counter counts iTICK_1S.
  - oALARM clears when the count reaches RING_SEC, or on any key press.
  - The dismissing press is consumed: no state change, no arm toggle.
- Reset values:
  - State RUN; all strobes 1; oDATA_* 0.
  - oALM_* 0; oARMED 0; oALARM 0; all counters 0.
  - Key history registers reset to 1, so a key held through reset does not register a press.

## Timing
- A key is first sampled low at edge N. At edge N the state, field and strobe registers update, so the effect is visible one cycle after the first low sample.
- All outputs are registered. There is no combinational path from input to output.
- The preset strobe is exactly one cycle wide and is asserted the cycle after the SET_M1 MODE press is sampled.
- Ring start: oALARM rises 2 cycles after the time inputs change to the matching value.
- Timeout: oALARM falls on the edge sampling the RING_SEC-th iTICK_1S after ring start.
- Asynchronous reset mid-edit or mid-ring: edits are discarded, no strobe is issued, ringing stops immediately.

## Configuration
- SNOOZE_EN defined:
  - INC press while ringing snoozes. oALARM clears and a snooze counter counts iTICK_1S.
  - At SNOOZE_SEC ticks, ringing restarts with a fresh RING_SEC timeout.
  - MODE press while ringing or snoozed dismisses and cancels the snooze.
  - Disarming in RUN cancels a pending snooze.
  - Leaving RUN does not cancel it; re-ringing is suppressed until the state is back in RUN.
- SNOOZE_EN undefined: any key dismisses, and no snooze logic is built.

## Structure
- Package clock_pkg holds:
  - the state encoding constants;
  - field maxima H_MAX=23, M10_MAX=5, M1_MAX=9;
  - field widths 5/3/4.
- One sub-module, key_edge, is instantiated once per key. It contains the history register and produces a one-cycle press pulse; its history register resets to 1.

## Test plan
- Reset, then MODE×3 and INC×2 in SET_M1 starting from time 07:3x: in SET_H, INC×17 takes hour 7→23→0. Final MODE → one-cycle strobes on all three presets with data H=0, M10=3, M1=x+2 (mod 10).
- Alarm set to 12:05 and armed; drive time 12:04→12:05 → oALARM rises 2 cycles later and falls after 30 ticks. Hold 12:05 → no re-ring.
- Ringing, INC press → oALARM=0 next cycle, state stays RUN, oARMED stays 1 (SNOOZE_EN undefined).
- With SNOOZE_EN, SNOOZE_SEC=3: INC while ringing → oALARM=0, re-rises on the 3rd tick. MODE while ringing → cleared with no re-ring.
- MODE and INC pressed in the same cycle in SET_H → advances to SET_M10, hour field unchanged.
- iRSTn pulsed low in ALM_M10 with edited fields → RUN, oALM_* unchanged, no strobes, oALARM=0.
